uart_tx_fifo: RTL

- Parametrised next-generation UART serialiser with a built-in transmit FIFO, optional parity bit, configurable data and stop bit counts, and back-to-back frame streaming.
- Sits between the reader control logic and the host serial line.
- Producers push bytes with a send/ready handshake.
- The block emits the frames LSB-first with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-facing handshake and serial line bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   logic [DATA_BITS-1:0]               tx_byte;
   logic                               send;
   logic                               ready;
   logic                               busy;
   logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level;
   logic                               tx_bits;

   modport master (
      output tx_byte, send,
      input  ready, busy, fifo_level, tx_bits
   );

   modport slave (
      input  tx_byte, send,
      output ready, busy, fifo_level, tx_bits
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART serialiser with transmit FIFO, optional parity and back-to-back frames
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0,
   parameter int CLK_RATE   = 12000000,
   parameter int BAUD_RATE  = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_fifo_if.slave  bus
);
   localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
   localparam int TW = $clog2(BIT_CYCLES);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(BIT_CYCLES - 1);
   localparam logic          PARITY_ODD   = (PARITY == 2);

   // Bad parameter combinations stop elaboration instead of producing a broken line format.
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0 (none), 1 (even) or 2 (odd)");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be in 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (BIT_CYCLES < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLK_RATE/BAUD_RATE must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state;
   logic [TW-1:0]         timer;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_BITS-1:0]  shift_reg;
   logic                  parity_bit;
   logic                  tx_q;

   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [LW-1:0]         count;

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  strobe;
   logic                  last_stop;
   logic [DATA_BITS-1:0]  head;
   logic                  head_parity;

   assign full        = (count == LW'(FIFO_DEPTH));
   assign empty       = (count == '0);
   assign push        = bus.send && !full;
   assign strobe      = (timer == '0);
   assign last_stop   = (state == S_STOP) && strobe && (bit_cnt == CW'(STOP_BITS - 1));
   // A frame is loaded either from idle or straight out of the final stop bit.
   assign pop         = !empty && ((state == S_IDLE) || last_stop);
   assign head        = mem[rd_ptr];
   assign head_parity = (^head) ^ PARITY_ODD;

   assign bus.ready      = !full;
   assign bus.busy       = (state != S_IDLE) || (count != '0);
   assign bus.fifo_level = count;
   assign bus.tx_bits    = tx_q;

   // FIFO storage: written on an accepted send, contents never need clearing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.tx_byte;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Frame sequencer: tx_q is loaded with the value of the next bit at each bit boundary.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         timer      <= TIMER_RELOAD;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               timer <= TIMER_RELOAD;
               tx_q  <= 1'b1;
               if (!empty) begin
                  shift_reg  <= head;
                  parity_bit <= head_parity;
                  state      <= S_START;
                  tx_q       <= 1'b0;
               end
            end
            S_START: begin
               if (strobe) begin
                  timer     <= TIMER_RELOAD;
                  state     <= S_DATA;
                  tx_q      <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= '0;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_DATA: begin
               if (strobe) begin
                  timer <= TIMER_RELOAD;
                  if (bit_cnt == CW'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY != 0) begin
                        state <= S_PARITY;
                        tx_q  <= parity_bit;
                     end else begin
                        state <= S_STOP;
                        tx_q  <= 1'b1;
                     end
                  end else begin
                     tx_q      <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= bit_cnt + CW'(1);
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_PARITY: begin
               if (strobe) begin
                  timer   <= TIMER_RELOAD;
                  state   <= S_STOP;
                  tx_q    <= 1'b1;
                  bit_cnt <= '0;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_STOP: begin
               if (strobe) begin
                  timer <= TIMER_RELOAD;
                  if (bit_cnt == CW'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (!empty) begin
                        shift_reg  <= head;
                        parity_bit <= head_parity;
                        state      <= S_START;
                        tx_q       <= 1'b0;
                     end else begin
                        state <= S_IDLE;
                        tx_q  <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               timer <= TIMER_RELOAD;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end
endmodule
